// File: rtl/mem_copy_engine_pkg.sv
// Shared constants for the memory copy/fill engine: state encodings, op codes, default memory size.
package mem_copy_engine_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_WR    = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  localparam int unsigned MEM_WORDS_DEFAULT = 101;

  // Address + length without 32-bit wrap.
  function automatic logic [32:0] ext_sum(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Word-granular copy/fill engine driving a single-port data memory from registered strobes.
//   state | meaning
//   IDLE  | waiting for start
//   CHECK | bounds / zero-length check, pick copy direction
//   RD    | read strobe for one source word
//   WR    | write strobe for one destination word
//   DONE  | one-cycle done pulse, busy drops on exit
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] src,
  input  logic [31:0] dst,
  input  logic [31:0] len,
  input  logic [31:0] fill_val,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] ad,
  output logic [31:0] wr,
  output logic        memtowrite,
  output logic        memtoread,
  input  logic [31:0] read
);

  localparam logic [32:0] LIMIT = 33'(MEM_WORDS);

  logic [2:0]  state_q, state_d;
  logic        op_q, op_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, len_q, len_d, fill_q, fill_d;
  logic        desc_q, desc_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic [31:0] ad_q, ad_d, wr_q, wr_d;
  logic        memtowrite_q, memtowrite_d, memtoread_q, memtoread_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [32:0] src_end, dst_end;
  logic        out_of_range, overlap_desc;
  logic [31:0] src_first, dst_first, src_next, dst_next;

  always_comb begin
    src_end      = ext_sum(src_q, len_q);
    dst_end      = ext_sum(dst_q, len_q);
    out_of_range = (dst_end > LIMIT) || ((op_q == OP_COPY) && (src_end > LIMIT));
    // Destination starting inside the source window would clobber unread words going upward.
    overlap_desc = (op_q == OP_COPY) && (src_q < dst_q) && ({1'b0, dst_q} < src_end);
    src_first    = overlap_desc ? (src_q + len_q - 32'd1) : src_q;
    dst_first    = overlap_desc ? (dst_q + len_q - 32'd1) : dst_q;
    src_next     = desc_q ? (src_ptr_q - 32'd1) : (src_ptr_q + 32'd1);
    dst_next     = desc_q ? (dst_ptr_q - 32'd1) : (dst_ptr_q + 32'd1);
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    fill_d       = fill_q;
    desc_d       = desc_q;
    remaining_d  = remaining_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    ad_d         = ad_q;
    wr_d         = wr_q;
    memtowrite_d = 1'b0;
    memtoread_d  = 1'b0;
    busy_d       = busy_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CHECK;
          op_d    = op;
          src_d   = src;
          dst_d   = dst;
          len_d   = len;
          fill_d  = fill_val;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      ST_CHECK: begin
        if (abort || out_of_range) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (len_q == 32'd0) begin
          state_d = ST_DONE;
        end else begin
          remaining_d = len_q;
          desc_d      = overlap_desc;
          src_ptr_d   = src_first;
          dst_ptr_d   = dst_first;
          if (op_q == OP_COPY) begin
            state_d     = ST_RD;
            ad_d        = src_first;
            memtoread_d = 1'b1;
          end else begin
            state_d      = ST_WR;
            ad_d         = dst_first;
            wr_d         = fill_q;
            memtowrite_d = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (abort) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d      = ST_WR;
          ad_d         = dst_ptr_q;
          wr_d         = read;
          memtowrite_d = 1'b1;
        end
      end
      ST_WR: begin
        if (abort) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (remaining_q == 32'd1) begin
          state_d = ST_DONE;
        end else begin
          remaining_d = remaining_q - 32'd1;
          src_ptr_d   = src_next;
          dst_ptr_d   = dst_next;
          if (op_q == OP_COPY) begin
            state_d     = ST_RD;
            ad_d        = src_next;
            memtoread_d = 1'b1;
          end else begin
            ad_d         = dst_next;
            wr_d         = fill_q;
            memtowrite_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_COPY;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      fill_q       <= '0;
      desc_q       <= 1'b0;
      remaining_q  <= '0;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      ad_q         <= '0;
      wr_q         <= '0;
      memtowrite_q <= 1'b0;
      memtoread_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      fill_q       <= fill_d;
      desc_q       <= desc_d;
      remaining_q  <= remaining_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      ad_q         <= ad_d;
      wr_q         <= wr_d;
      memtowrite_q <= memtowrite_d;
      memtoread_q  <= memtoread_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign ad         = ad_q;
  assign wr         = wr_q;
  assign memtowrite = memtowrite_q;
  assign memtoread  = memtoread_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural 128-word memory and strobe monitors.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] src = '0, dst = '0, len = '0, fill_val = '0;
  logic        abort = 1'b0;
  logic        busy, done, err, memtowrite, memtoread;
  logic [31:0] ad, wr, read;

  logic [31:0] mem [0:127];
  logic [31:0] wlog [0:255];
  logic        preload = 1'b1;
  int          wcnt = 0;
  int          rcnt = 0;
  int          both_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  mem_copy_engine #(.MEM_WORDS(101)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .abort(abort), .busy(busy), .done(done),
    .err(err), .ad(ad), .wr(wr), .memtowrite(memtowrite), .memtoread(memtoread),
    .read(read)
  );

  always #5 clk = ~clk;

  assign read = memtoread ? mem[ad[6:0]] : 32'd0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
      mem[0] <= 32'd4; mem[1] <= 32'd6; mem[2] <= 32'd9; mem[3] <= 32'd2; mem[4] <= 32'd7;
    end else begin
      if (memtowrite) begin
        mem[ad[6:0]] <= wr;
        wlog[wcnt[7:0]] <= ad;
        wcnt <= wcnt + 1;
      end
      if (memtoread) rcnt <= rcnt + 1;
      if (memtoread && memtowrite) both_cnt <= both_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic o, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] l, input logic [31:0] f);
    @(negedge clk);
    op = o; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic o, input logic [31:0] s, input logic [31:0] d,
                     input logic [31:0] l, input logic [31:0] f,
                     input int exp_lat, input logic exp_err);
    int lat;
    start_op(o, s, d, l, f);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int w0, r0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {27'd0, busy, done, err, memtowrite, memtoread}, 32'd0);
    chk("rst_ad", ad, 32'd0);
    chk("rst_wr", wr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    preload = 1'b0;

    // Plain copy
    w0 = wcnt; r0 = rcnt;
    run("copy", 1'b0, 32'd0, 32'd50, 32'd5, 32'd0, 12, 1'b0);
    chk("copy_m50", mem[50], 32'd4);
    chk("copy_m51", mem[51], 32'd6);
    chk("copy_m52", mem[52], 32'd9);
    chk("copy_m53", mem[53], 32'd2);
    chk("copy_m54", mem[54], 32'd7);
    chk("copy_nw", wcnt - w0, 32'd5);
    chk("copy_nr", rcnt - r0, 32'd5);

    // Overlapping copy goes downward
    w0 = wcnt;
    run("ovl", 1'b0, 32'd0, 32'd2, 32'd5, 32'd0, 12, 1'b0);
    for (int k = 0; k < 5; k++) chk("ovl_order", wlog[(w0 + k) % 256], 32'(6 - k));
    chk("ovl_m2", mem[2], 32'd4);
    chk("ovl_m3", mem[3], 32'd6);
    chk("ovl_m4", mem[4], 32'd9);
    chk("ovl_m5", mem[5], 32'd2);
    chk("ovl_m6", mem[6], 32'd7);

    // dst == src+len is not an overlap: ascending
    w0 = wcnt;
    run("adj", 1'b0, 32'd0, 32'd5, 32'd5, 32'd0, 12, 1'b0);
    chk("adj_first", wlog[w0 % 256], 32'd5);
    chk("adj_m5", mem[5], 32'd4);
    chk("adj_m9", mem[9], 32'd9);

    // Fill
    w0 = wcnt; r0 = rcnt;
    run("fill", 1'b1, 32'd0, 32'd60, 32'd3, 32'd777, 5, 1'b0);
    chk("fill_m60", mem[60], 32'd777);
    chk("fill_m62", mem[62], 32'd777);
    chk("fill_m63", mem[63], 32'd0);
    chk("fill_nr", rcnt - r0, 32'd0);
    chk("fill_nw", wcnt - w0, 32'd3);

    // Bounds
    w0 = wcnt; r0 = rcnt;
    run("oob", 1'b0, 32'd98, 32'd0, 32'd5, 32'd0, 2, 1'b1);
    chk("oob_nstrobe", (wcnt - w0) + (rcnt - r0), 32'd0);
    chk("oob_m0", mem[0], 32'd4);
    @(posedge clk); #1;
    chk("oob_err_hold", {31'd0, err}, 32'd1);
    run("fill_edge", 1'b1, 32'hFFFF_0000, 32'd98, 32'd3, 32'd5, 5, 1'b0);
    chk("fill_edge_m100", mem[100], 32'd5);
    w0 = wcnt;
    run("fill_oob", 1'b1, 32'd0, 32'd99, 32'd3, 32'd8, 2, 1'b1);
    chk("fill_oob_nw", wcnt - w0, 32'd0);
    w0 = wcnt; r0 = rcnt;
    run("len0", 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 2, 1'b0);
    chk("len0_nstrobe", (wcnt - w0) + (rcnt - r0), 32'd0);

    // Abort in second read
    w0 = wcnt;
    start_op(1'b0, 32'd0, 32'd70, 32'd5, 32'd0);
    @(posedge clk); #1;
    chk("ab_rd1", {31'd0, memtoread}, 32'd1);
    @(posedge clk); #1;
    chk("ab_wr1", {31'd0, memtowrite}, 32'd1);
    @(posedge clk); #1;
    chk("ab_rd2", {31'd0, memtoread}, 32'd1);
    chk("ab_rd2_ad", ad, 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab_done", {29'd0, done, err, memtoread | memtowrite}, 32'd6);
    @(posedge clk); #1;
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_nw", wcnt - w0, 32'd1);
    chk("ab_m70", mem[70], 32'd4);
    chk("ab_m71", mem[71], 32'd0);

    // Reset mid-fill
    w0 = wcnt;
    start_op(1'b1, 32'd0, 32'd80, 32'd5, 32'd33);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rf_wr2", {31'd0, memtowrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rf_async", {29'd0, busy, memtowrite, memtoread}, 32'd0);
    chk("rf_ad", ad, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rf_quiet", {30'd0, memtowrite, busy}, 32'd0);
    chk("rf_nw", wcnt - w0, 32'd1);
    chk("rf_m80", mem[80], 32'd33);
    chk("rf_m81", mem[81], 32'd0);
    chk("rf_m84", mem[84], 32'd0);

    chk("no_overlap_strobes", both_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
